// File: rtl/countdown_timer.sv
// Loadable down-counter with pause and abort; emits a one-cycle done pulse
// when a countdown reaches zero. Four-state control FSM around a T-flip-flop style decrementer.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] count_dec;
  logic             load_accept;

  // Bit i flips exactly when every lower bit is zero.
  assign toggle[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
    assign toggle[i] = ~|count_q[i-1:0];
  end
  assign count_dec = count_q ^ toggle;

  assign load_ready  = (state_q == IDLE) || (state_q == DONE);
  assign load_accept = load_valid && load_ready && !abort;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (load_accept) begin
            count_d = load_value;
            state_d = (load_value == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (count_q != '0) begin
            count_d = count_dec;
            if (count_q == {{(WIDTH-1){1'b0}}, 1'b1}) state_d = DONE;
          end else begin
            // Defensive: RUN should never hold zero, but never wrap.
            state_d = DONE;
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count     = count_q;
  assign busy      = (state_q == RUN) || (state_q == PAUSED);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule
